// File: rtl/axi_frame_rd_slave_if.sv
// AXI4 read-channel bundle (AR + R) between the line fetcher and the frame
// buffer responder.
interface axi_frame_rd_slave_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] araddr_i;
  logic [1:0]            arburst_i;
  logic [7:0]            arlen_i;
  logic [2:0]            arsize_i;
  logic                  arvalid_i;
  logic                  arready_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic [1:0]            rresp_o;
  logic                  rlast_o;
  logic                  rvalid_o;
  logic                  rready_i;

  modport master (
    output araddr_i, arburst_i, arlen_i, arsize_i, arvalid_i, rready_i,
    input  arready_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );

  modport slave (
    input  araddr_i, arburst_i, arlen_i, arsize_i, arvalid_i, rready_i,
    output arready_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );
endinterface

// File: rtl/axi_frame_rd_slave.sv
// AXI4 read responder over an internal word-addressed frame memory, with a
// backdoor write port for preloading pixel data.
module axi_frame_rd_slave #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         clk_a,
  input  logic                         reset,
  input  logic                         wr_en_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]        wr_data_i,
  axi_frame_rd_slave_if.slave          axi
);
  localparam int MA = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {IDLE, BURST} state_t;

  state_t state, state_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [1:0]            burst_q;
  logic [2:0]            size_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt;

  logic                  arready_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  ar_fire;
  logic                  r_fire;
  logic                  last_beat;
  logic                  advance;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [ADDR_WIDTH-1:0] ld_idx;
  logic                  ld_in_range;
  logic [1:0]            ld_burst;
  logic [2:0]            ld_size;
  logic                  ld_last;
  logic [1:0]            ld_resp;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  wr_ok;

  // Protocol errors dominate; range is only judged for legal bursts.
  function automatic logic [1:0] beat_resp(input logic [1:0] burst,
                                           input logic [2:0] size,
                                           input logic       in_range);
    if (burst[1] || size != 3'd3) return RESP_SLVERR;
    if (!in_range)                return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  always_comb begin
    ar_fire   = (state == IDLE) && arready_q && axi.arvalid_i;
    r_fire    = (state == BURST) && rvalid_q && axi.rready_i;
    last_beat = (cnt == len_q);
    advance   = r_fire && !last_beat;

    state_d = state;
    case (state)
      IDLE:    if (ar_fire) state_d = BURST;
      BURST:   if (r_fire && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat load: the AR handshake loads beat 0 straight from the request.
  always_comb begin
    if (ar_fire) begin
      ld_addr  = axi.araddr_i;
      ld_burst = axi.arburst_i;
      ld_size  = axi.arsize_i;
      ld_last  = (axi.arlen_i == 8'd0);
    end else begin
      ld_addr  = (burst_q == 2'b00) ? cur_addr : cur_addr + ADDR_WIDTH'(8);
      ld_burst = burst_q;
      ld_size  = size_q;
      ld_last  = ((cnt + 8'd1) == len_q);
    end
    ld_idx      = ld_addr >> 3;
    ld_in_range = (ld_idx < ADDR_WIDTH'(MEM_DEPTH));
    ld_resp     = beat_resp(ld_burst, ld_size, ld_in_range);
    ld_data     = (ld_resp == RESP_OKAY) ? mem[ld_idx[MA-1:0]] : '0;
    wr_ok       = (32'(wr_addr_i) < 32'(MEM_DEPTH));
  end

  always_ff @(posedge clk_a) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk_a) begin
    if (reset) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      cnt       <= '0;
    end else begin
      arready_q <= (state_d == IDLE);
      if (ar_fire)      cnt <= '0;
      else if (advance) cnt <= cnt + 8'd1;

      if (ar_fire || advance) begin
        rvalid_q <= 1'b1;
        rlast_q  <= ld_last;
        rresp_q  <= ld_resp;
        rdata_q  <= ld_data;
      end else if (r_fire) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_a) begin
    if (ar_fire) begin
      burst_q <= axi.arburst_i;
      size_q  <= axi.arsize_i;
      len_q   <= axi.arlen_i;
    end
    if (ar_fire || advance) cur_addr <= ld_addr;
  end

  // Nonblocking write gives read-before-write against a same-cycle beat load.
  always_ff @(posedge clk_a) begin
    if (wr_en_i && wr_ok) mem[wr_addr_i] <= wr_data_i;
  end

  assign axi.arready_o = arready_q;
  assign axi.rvalid_o  = rvalid_q;
  assign axi.rlast_o   = rlast_q;
  assign axi.rresp_o   = rresp_q;
  assign axi.rdata_o   = rdata_q;
endmodule

// File: tb/tb_axi_frame_rd_slave.sv
// Bench for axi_frame_rd_slave: burst-level reference model plus directed
// scenarios with literal expectations.
module tb_axi_frame_rd_slave;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MD = 1024;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  r;
    logic        l;
  } beat_t;

  logic        clk_a = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;

  always #5 clk_a = ~clk_a;

  axi_frame_rd_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_frame_rd_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(MD)) dut (
    .clk_a     (clk_a),
    .reset     (reset),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .axi       (bus.slave)
  );

  int checks = 0;
  int passed = 0;

  logic [63:0] mmem [MD];
  beat_t       expq [$];
  beat_t       log_q [$];
  logic        rst_q = 1'b1;
  logic        arready_s = 1'b0;
  logic [63:0] m_a, m_idx;
  beat_t       m_b, c_b;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  // Model: an accepted AR expands into its full list of beats by address arithmetic.
  always @(posedge clk_a) begin
    if (reset) begin
      expq.delete();
    end else if (bus.arvalid_i && arready_s) begin
      for (int k = 0; k <= int'(bus.arlen_i); k++) begin
        m_a = (bus.arburst_i == 2'b00) ? bus.araddr_i : bus.araddr_i + 64'(8 * k);
        m_b.l = (k == int'(bus.arlen_i));
        if (bus.arburst_i[1] || bus.arsize_i != 3'd3) begin
          m_b.d = '0; m_b.r = 2'b10;
        end else begin
          m_idx = m_a >> 3;
          if (m_idx >= 64'(MD)) begin
            m_b.d = '0; m_b.r = 2'b11;
          end else begin
            m_b.d = mmem[m_idx[9:0]]; m_b.r = 2'b00;
          end
        end
        expq.push_back(m_b);
      end
    end
    if (wr_en) mmem[wr_addr] = wr_data;
    rst_q = reset;
  end

  always @(negedge clk_a) begin
    arready_s = bus.arready_o;
    if (rst_q) begin
      chk("rst_arready", 64'(bus.arready_o), 64'd0);
      chk("rst_rvalid",  64'(bus.rvalid_o),  64'd0);
    end else begin
      chk("arready", 64'(bus.arready_o), 64'(expq.size() == 0));
      if (expq.size() == 0) begin
        if (bus.rvalid_o) chk("spurious_rvalid", 64'(bus.rvalid_o), 64'd0);
      end else begin
        chk("rvalid", 64'(bus.rvalid_o), 64'd1);
        if (bus.rvalid_o) begin
          chk("rdata", bus.rdata_o, expq[0].d);
          chk("rresp", 64'(bus.rresp_o), 64'(expq[0].r));
          chk("rlast", 64'(bus.rlast_o), 64'(expq[0].l));
          if (bus.rready_i) begin
            c_b.d = bus.rdata_o; c_b.r = bus.rresp_o; c_b.l = bus.rlast_o;
            log_q.push_back(c_b);
            void'(expq.pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_a); #1;
  endtask

  task automatic ar(input logic [63:0] addr, input logic [1:0] burst,
                    input logic [7:0] len, input logic [2:0] size);
    bit acc = 1'b0;
    log_q.delete();
    bus.araddr_i = addr; bus.arburst_i = burst; bus.arlen_i = len; bus.arsize_i = size;
    bus.arvalid_i = 1'b1;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk_a);
      acc = bus.arready_o;
      tick();
    end
    bus.arvalid_i = 1'b0;
    if (!acc) chk("ar_timeout", 64'd0, 64'd1);
  endtask

  task automatic run(input bit rnd, input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      bus.rready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk_a);
      if (expq.size() == 0 && !bus.rvalid_o) done = 1'b1;
      tick();
    end
    bus.rready_i = 1'b1;
    if (!done) chk("burst_timeout", 64'd0, 64'd1);
  endtask

  task automatic chk_beat(input string nm, input int k, input logic [63:0] d,
                          input logic [1:0] r, input logic l);
    if (k >= log_q.size()) begin
      chk({nm, "_missing"}, 64'(log_q.size()), 64'(k + 1));
    end else begin
      chk({nm, "_data"}, log_q[k].d, d);
      chk({nm, "_resp"}, 64'(log_q[k].r), 64'(r));
      chk({nm, "_last"}, 64'(log_q[k].l), 64'(l));
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    bus.araddr_i = '0; bus.arburst_i = 2'b01; bus.arlen_i = '0; bus.arsize_i = 3'd3;
    bus.arvalid_i = 1'b0; bus.rready_i = 1'b1;
    tick(); tick();
    chk("reset_rdata", bus.rdata_o, 64'd0);
    chk("reset_rresp", 64'(bus.rresp_o), 64'd0);
    chk("reset_rlast", 64'(bus.rlast_o), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < MD; i++) begin
      wr_en = 1'b1; wr_addr = 10'(i); wr_data = 64'hA000 + 64'(i);
      tick();
    end
    wr_en = 1'b0;

    // Reset held 3 cycles with a pending AR, then INCR burst from 0x40.
    log_q.delete();
    bus.araddr_i = 64'h40; bus.arburst_i = 2'b01; bus.arlen_i = 8'd7; bus.arsize_i = 3'd3;
    bus.arvalid_i = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk_a);
      chk("hold_arready", 64'(bus.arready_o), 64'd0);
      chk("hold_rvalid", 64'(bus.rvalid_o), 64'd0);
    end
    reset = 1'b0;
    tick();
    @(negedge clk_a);
    chk("post_reset_arready", 64'(bus.arready_o), 64'd1);
    tick();
    bus.arvalid_i = 1'b0;
    run(1'b0, 40);
    chk("incr_count", 64'(log_q.size()), 64'd8);
    chk_beat("incr_b0", 0, 64'hA008, 2'b00, 1'b0);
    chk_beat("incr_b6", 6, 64'hA00E, 2'b00, 1'b0);
    chk_beat("incr_b7", 7, 64'hA00F, 2'b00, 1'b1);

    // 256-beat burst under random backpressure.
    ar(64'h40, 2'b01, 8'd255, 3'd3);
    run(1'b1, 4000);
    chk("bp_count", 64'(log_q.size()), 64'd256);
    for (int k = 0; k < log_q.size() && k < 256; k++)
      chk("bp_seq", log_q[k].d, 64'hA008 + 64'(k));

    // FIXED burst with an AR presented mid-burst that must be ignored.
    ar(64'h18, 2'b00, 8'd3, 3'd3);
    bus.araddr_i = 64'h0; bus.arvalid_i = 1'b1;
    tick(); tick();
    bus.arvalid_i = 1'b0;
    run(1'b0, 40);
    chk("fixed_count", 64'(log_q.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      chk_beat("fixed", k, 64'hA003, 2'b00, k == 3);

    ar(64'h40, 2'b10, 8'd3, 3'd3);
    run(1'b0, 40);
    chk("slverr_count", 64'(log_q.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      chk_beat("slverr", k, 64'd0, 2'b10, k == 3);

    ar(64'h40, 2'b01, 8'd0, 3'd2);
    run(1'b0, 40);
    chk("badsize_count", 64'(log_q.size()), 64'd1);
    chk_beat("badsize", 0, 64'd0, 2'b10, 1'b1);

    ar(64'h1FF0, 2'b01, 8'd3, 3'd3);
    run(1'b0, 40);
    chk("oor_count", 64'(log_q.size()), 64'd4);
    chk_beat("oor_b0", 0, 64'hA3FE, 2'b00, 1'b0);
    chk_beat("oor_b1", 1, 64'hA3FF, 2'b00, 1'b0);
    chk_beat("oor_b2", 2, 64'd0, 2'b11, 1'b0);
    chk_beat("oor_b3", 3, 64'd0, 2'b11, 1'b1);

    // Reset after beat 2 of a 16-beat burst.
    begin
      int n = 0;
      int guard = 0;
      ar(64'h0, 2'b01, 8'd15, 3'd3);
      bus.rready_i = 1'b1;
      while (n < 3 && guard < 40) begin
        @(negedge clk_a);
        if (bus.rvalid_o && bus.rready_i) n++;
        tick();
        guard++;
      end
      if (n < 3) chk("midreset_timeout", 64'(n), 64'd3);
    end
    bus.rready_i = 1'b0;
    reset = 1'b1;
    tick();
    @(negedge clk_a);
    chk("midreset_rvalid", 64'(bus.rvalid_o), 64'd0);
    chk("midreset_rdata", bus.rdata_o, 64'd0);
    chk("midreset_rlast", 64'(bus.rlast_o), 64'd0);
    reset = 1'b0;
    bus.rready_i = 1'b1;
    tick();
    ar(64'h10, 2'b01, 8'd1, 3'd3);
    run(1'b0, 40);
    chk("after_reset_count", 64'(log_q.size()), 64'd2);
    chk_beat("after_reset_b1", 1, 64'hA003, 2'b00, 1'b1);

    // Backdoor write to word 5 on the edge that loads beat 5.
    bus.rready_i = 1'b1;
    ar(64'h0, 2'b01, 8'd7, 3'd3);
    tick(); tick(); tick(); tick();
    wr_en = 1'b1; wr_addr = 10'd5; wr_data = 64'hDEAD;
    tick();
    wr_en = 1'b0;
    run(1'b0, 40);
    chk_beat("collide_b5", 5, 64'hA005, 2'b00, 1'b0);
    ar(64'h28, 2'b00, 8'd0, 3'd3);
    run(1'b0, 40);
    chk_beat("collide_after", 0, 64'hDEAD, 2'b00, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
